camo_key_loader: RTL and testbench
==================================

Name: camo_key_loader

Overview:
- Writer-side counterpart to the camouflaged-cell key inputs of the obfuscated benchmark netlists.
- Accepts a serial key stream with a valid/ready handshake and verifies it against a CRC-8 trailer.
- On a pass, commits the key atomically to a parallel bus that drives the per-cell select pins (D_0..D_{KEY_W-1}).
- Sits between the test/activation controller and the obfuscated combinational core; the core never sees a partial or unverified key.

Parameters:
- N_CELLS, 5, number of camouflaged cells; each cell takes 2 select bits.
- KEY_W, 2*N_CELLS, key bus width (derived; not overridable independently).
- CRC_W, 8, trailer width. CRC-8 uses poly 0x07, init 0x00, MSB-first, no reflection, no final xor.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous assert, active-low reset.
- load_start, in, 1: one-cycle pulse that requests a new key load.
- key_bit_in, in, 1: serial key/CRC data bit.
- key_bit_valid, in, 1: key_bit_in is valid this cycle.
- key_bit_ready, out, 1: loader accepts a bit this cycle.
- key_out, out, KEY_W: committed key. key_out[2i] = D_{2i}, key_out[2i+1] = D_{2i+1}.
- key_locked, out, 1: key_out holds a verified key.
- crc_error, out, 1: the last load failed CRC; sticky until the next load_start.
- busy, out, 1: a load is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - key_out=0: all cells in code 00 (buffer).
  - key_locked=0, crc_error=0, busy=0, key_bit_ready=0.
  - Shift register, CRC register and bit counter all cleared.
  - Reset mid-load discards the partial key.
- Cell code per pair {D_{2i+1},D_{2i}}: 00 buffer, 10 inverter, 01 const1, 11 const0. All four codes are legal; the loader does not validate codes.
- States:
  - IDLE: key_bit_ready=0. load_start moves to SHIFT next cycle and clears counter, CRC and crc_error. key_out and key_locked are held.
  - SHIFT: key_bit_ready=1 and busy=1.
    - A bit transfers only when key_bit_valid && key_bit_ready.
    - The first bit transferred ends up in the MSB of the shift register.
    - The CRC updates on every transferred bit: the KEY_W key bits, then the CRC_W trailer bits.
    - After KEY_W+CRC_W transfers, go to CHECK. The ready deassert and state change take effect the cycle after the final transfer.
    - Cycles with valid=0 stall without any timeout.
    - load_start is ignored.
  - CHECK (1 cycle, busy=1, ready=0):
    - Residue==0: go to COMMIT.
    - Otherwise: go to ERROR.
  - COMMIT (1 cycle): key_out <= shift[KEY_W-1:0], key_locked <= 1, then IDLE. This is the only cycle in which key_out changes to a nonzero value.
  - ERROR (1 cycle): key_out <= 0, key_locked <= 0, crc_error <= 1, then IDLE.
- Reload:
  - load_start in IDLE while locked starts a new load; the old key stays on key_out during SHIFT/CHECK.
  - If the new load fails, the old key is cleared (fail-secure).
- Latency: the last trailer bit accepted at cycle t gives CHECK at t+1; key_out/key_locked update visibly at t+3. The timing is the same for both outcomes.
- Simultaneous events:
  - load_start in COMMIT/ERROR is ignored.
  - The controller must wait for busy=0.
- Width rules:
  - The bit counter is clog2(KEY_W+CRC_W+1) bits wide and saturates at its terminal count.
  - The CRC register is CRC_W bits wide; update: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0).

Decomposition:
- Package camo_key_pkg:
  - state enum {IDLE, SHIFT, CHECK, COMMIT, ERROR}.
  - CRC_POLY=8'h07.
  - cell-code constants CODE_BUF=2'b00, CODE_INV=2'b10, CODE_ONE=2'b01, CODE_ZERO=2'b11.
- One sub-module: camo_crc8_serial. A bitwise CRC with clear, enable and data_in, which exposes the residue. The rest (FSM, counter, shift and shadow registers) stays in camo_key_loader.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT after 6 bits -> key_out=0, key_locked=0, busy=0 immediately. After release, the loader is in IDLE with ready=0.
- Good load: load_start, then stream key 10'b0001101100 and CRC 8'h03 MSB-first with continuous valid -> key_out=10'h06C, key_locked=1 exactly 3 cycles after the last bit, crc_error=0.
- Bad CRC: same key with trailer 8'h02 -> key_out=0, key_locked=0, crc_error=1; key_out never shows 10'h06C.
- Backpressure/stall: toggle key_bit_valid randomly during the good load -> same result. Exactly 18 transfers counted, and ready=0 from CHECK on.
- Reload fail-secure: lock 10'h06C, then start a load of 10'h3FF with a wrong CRC -> key_out stays 10'h06C through SHIFT, then becomes 0 with crc_error=1.
- Ignored start: pulse load_start during SHIFT and during COMMIT -> no restart, bit count unaffected, final key_out=10'h06C.

Source files
------------

// File: rtl/camo_key_pkg.sv
// Shared types and constants for the camouflaged-cell key loader.
package camo_key_pkg;

    localparam int unsigned N_CELLS = 5;
    localparam int unsigned KEY_W   = 2 * N_CELLS;
    localparam int unsigned CRC_W   = 8;
    localparam int unsigned FRAME_W = KEY_W + CRC_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

    // Per-cell select codes {D_{2i+1}, D_{2i}}
    localparam logic [1:0] CODE_BUF  = 2'b00;
    localparam logic [1:0] CODE_INV  = 2'b10;
    localparam logic [1:0] CODE_ONE  = 2'b01;
    localparam logic [1:0] CODE_ZERO = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        CHECK  = 3'd2,
        COMMIT = 3'd3,
        ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/camo_key_loader_if.sv
// Controller-to-loader bundle: serial key stream in, committed key and status out.
interface camo_key_loader_if;
    import camo_key_pkg::*;

    logic             load_start;
    logic             key_bit_in;
    logic             key_bit_valid;
    logic             key_bit_ready;
    logic [KEY_W-1:0] key_out;
    logic             key_locked;
    logic             crc_error;
    logic             busy;

    modport master (
        output load_start, key_bit_in, key_bit_valid,
        input  key_bit_ready, key_out, key_locked, crc_error, busy
    );

    modport slave (
        input  load_start, key_bit_in, key_bit_valid,
        output key_bit_ready, key_out, key_locked, crc_error, busy
    );
endinterface

// File: rtl/camo_crc8_serial.sv
// Bit-serial MSB-first CRC-8 (init 0, no reflection, no final xor); residue is the register itself.
module camo_crc8_serial
    import camo_key_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             data_in,
    output logic [CRC_W-1:0] residue
);

    logic [CRC_W-1:0] crc_q;
    logic             fb_c;

    assign fb_c    = crc_q[CRC_W-1] ^ data_in;
    assign residue = crc_q;

    // Clear wins over enable so a new load always starts from the init value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else if (clear) begin
            crc_q <= '0;
        end else if (enable) begin
            crc_q <= {crc_q[CRC_W-2:0], 1'b0} ^ (fb_c ? CRC_POLY : CRC_W'(0));
        end
    end

endmodule

// File: rtl/camo_key_loader.sv
// Serial key loader: shifts in key + CRC trailer, verifies, and commits the key atomically.
module camo_key_loader
    import camo_key_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    camo_key_loader_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_KEY  = CNT_W'(KEY_W);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [KEY_W-1:0] shift_q, shift_next;
    logic [KEY_W-1:0] key_q, key_next;
    logic             locked_q, locked_next;
    logic             err_q, err_next;
    logic             ready_q, ready_next;
    logic             busy_q, busy_next;

    logic             xfer_c;
    logic             crc_clear_c;
    logic [CRC_W-1:0] residue;

    assign xfer_c = (state == SHIFT) && ready_q && bus.key_bit_valid;

    camo_crc8_serial u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (crc_clear_c),
        .enable  (xfer_c),
        .data_in (bus.key_bit_in),
        .residue (residue)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            shift_q  <= '0;
            key_q    <= '0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            shift_q  <= shift_next;
            key_q    <= key_next;
            locked_q <= locked_next;
            err_q    <= err_next;
            ready_q  <= ready_next;
            busy_q   <= busy_next;
        end
    end

    // Next-state and register-update logic; key_out only moves in COMMIT/ERROR
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        shift_next  = shift_q;
        key_next    = key_q;
        locked_next = locked_q;
        err_next    = err_q;
        crc_clear_c = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.load_start) begin
                    state_next  = SHIFT;
                    cnt_next    = '0;
                    shift_next  = '0;
                    err_next    = 1'b0;
                    crc_clear_c = 1'b1;
                end
            end
            SHIFT: begin
                if (xfer_c) begin
                    cnt_next = (cnt == CNT_TERM) ? cnt : cnt + CNT_W'(1);
                    // Only key bits are kept; trailer bits feed the CRC alone
                    if (cnt < CNT_KEY) begin
                        shift_next = {shift_q[KEY_W-2:0], bus.key_bit_in};
                    end
                    if (cnt == CNT_LAST) begin
                        state_next = CHECK;
                    end
                end
            end
            CHECK: begin
                state_next = (residue == CRC_W'(0)) ? COMMIT : ERROR;
            end
            COMMIT: begin
                key_next    = shift_q;
                locked_next = 1'b1;
                state_next  = IDLE;
            end
            ERROR: begin
                key_next    = '0;
                locked_next = 1'b0;
                err_next    = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready_next = (state_next == SHIFT);
    assign busy_next  = (state_next != IDLE);

    assign bus.key_bit_ready = ready_q;
    assign bus.busy          = busy_q;
    assign bus.key_out       = key_q;
    assign bus.key_locked    = locked_q;
    assign bus.crc_error     = err_q;

endmodule

// File: tb/tb_camo_key_loader.sv
// Directed self-checking bench for camo_key_loader.
module tb_camo_key_loader;
    import camo_key_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mon_xfers = 0;

    camo_key_loader_if bus();

    camo_key_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.key_bit_valid === 1'b1 && bus.key_bit_ready === 1'b1) mon_xfers++;
    end

    localparam logic [9:0] KEY_GOOD = 10'b0001101100;
    localparam logic [7:0] CRC_GOOD = 8'h03;

    // Full load: start pulse, 18-bit frame, then CHECK and COMMIT/ERROR with latency checks
    task automatic run_load(input logic [9:0] key, input logic [7:0] crc, input bit stall,
                            input int start_at, input bit start_commit,
                            input logic [9:0] old_key, input logic old_locked,
                            input logic [9:0] exp_key, input logic exp_locked, input logic exp_err);
        logic [17:0] frame;
        logic        rdy, vld;
        int          idx, cyc, base;
        bit          hold_bad;
        frame = {key, crc};
        idx = 0; cyc = 0; hold_bad = 0;
        base = mon_xfers;
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.crc_error !== 1'b0 || bus.key_bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start: busy=%b err=%b ready=%b, required 1 0 1",
                     bus.busy, bus.crc_error, bus.key_bit_ready);
        end
        while (idx < 18 && cyc < 400) begin
            vld = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.key_bit_valid = vld;
            bus.key_bit_in    = frame[17 - idx];
            bus.load_start    = (start_at >= 0 && idx == start_at) ? 1'b1 : 1'b0;
            rdy = bus.key_bit_ready;
            @(posedge clk);
            if (vld && rdy) idx++;
            #1;
            cyc++;
            if (idx < 18 && bus.key_out !== old_key) hold_bad = 1;
        end
        bus.key_bit_valid = 1'b0;
        bus.load_start    = 1'b0;
        n_checks++;
        if (idx < 18) begin
            n_fail++;
            $display("FAIL stream_timeout: %0d bits accepted, required 18", idx);
        end
        n_checks++;
        if (hold_bad) begin
            n_fail++;
            $display("FAIL key_hold_shift: key_out changed during SHIFT, required %h", old_key);
        end
        n_checks++;
        if (bus.key_bit_ready !== 1'b0 || bus.busy !== 1'b1 || bus.key_out !== old_key) begin
            n_fail++;
            $display("FAIL check_state: ready=%b busy=%b key=%h, required 0 1 %h",
                     bus.key_bit_ready, bus.busy, bus.key_out, old_key);
        end
        if (start_commit) bus.load_start = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.key_out !== old_key || bus.key_locked !== old_locked || bus.key_bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_update: key=%h locked=%b ready=%b, required %h %b 0",
                     bus.key_out, bus.key_locked, bus.key_bit_ready, old_key, old_locked);
        end
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        n_checks++;
        if (bus.key_out !== exp_key || bus.key_locked !== exp_locked || bus.crc_error !== exp_err) begin
            n_fail++;
            $display("FAIL result: key=%h locked=%b err=%b, required %h %b %b",
                     bus.key_out, bus.key_locked, bus.crc_error, exp_key, exp_locked, exp_err);
        end
        n_checks++;
        if (mon_xfers - base !== 18) begin
            n_fail++;
            $display("FAIL xfer_count: %0d transfers, required 18", mon_xfers - base);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.key_bit_ready !== 1'b0 || bus.key_out !== exp_key) begin
            n_fail++;
            $display("FAIL idle_after: busy=%b ready=%b key=%h, required 0 0 %h",
                     bus.busy, bus.key_bit_ready, bus.key_out, exp_key);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.load_start = 1'b0; bus.key_bit_in = 1'b0; bus.key_bit_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (bus.key_out !== 10'h000 || bus.key_locked !== 1'b0 || bus.crc_error !== 1'b0 ||
            bus.busy !== 1'b0 || bus.key_bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: key=%h locked=%b err=%b busy=%b ready=%b, required 000 0 0 0 0",
                     bus.key_out, bus.key_locked, bus.crc_error, bus.busy, bus.key_bit_ready);
        end
    endtask

    task automatic test_good_load();
        run_load(KEY_GOOD, CRC_GOOD, 1'b0, -1, 1'b0, 10'h000, 1'b0, 10'h06C, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_load();
        logic [17:0] frame;
        frame = {KEY_GOOD, CRC_GOOD};
        bus.load_start = 1'b1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.key_bit_valid = 1'b1;
            bus.key_bit_in    = frame[17 - i];
            @(posedge clk); #1;
        end
        bus.key_bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.key_out !== 10'h000 || bus.key_locked !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_load: key=%h locked=%b busy=%b, required 000 0 0",
                     bus.key_out, bus.key_locked, bus.busy);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.key_bit_ready !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: ready=%b busy=%b, required 0 0",
                     bus.key_bit_ready, bus.busy);
        end
    endtask

    task automatic test_bad_crc();
        run_load(KEY_GOOD, 8'h02, 1'b0, -1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        run_load(KEY_GOOD, CRC_GOOD, 1'b1, -1, 1'b0, 10'h000, 1'b0, 10'h06C, 1'b1, 1'b0);
    endtask

    task automatic test_reload_fail_secure();
        run_load(10'h3FF, 8'h00, 1'b0, -1, 1'b0, 10'h06C, 1'b1, 10'h000, 1'b0, 1'b1);
    endtask

    task automatic test_ignored_start();
        run_load(KEY_GOOD, CRC_GOOD, 1'b0, -1, 1'b0, 10'h000, 1'b0, 10'h06C, 1'b1, 1'b0);
        run_load(KEY_GOOD, CRC_GOOD, 1'b1, 7, 1'b1, 10'h06C, 1'b1, 10'h06C, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_reset_mid_load();
        test_bad_crc();
        test_backpressure();
        test_reload_fail_secure();
        test_ignored_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
